// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared defaults and FSM state encoding for cache_axi_master.
// Contents:
//   *_DEF     default parameter values (address, line, tag, ID widths, timeout)
//   state_t   transaction FSM states
//   tmr_width helper that sizes the per-phase timeout counter
package cache_axi_pkg;

    localparam int ADDR_W_DEF      = 64;
    localparam int DATA_W_DEF      = 512;
    localparam int TAG_W_DEF       = 64;
    localparam int ID_W_DEF        = 16;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4,
        RESP = 3'd5
    } state_t;

    // The timer counts 0 .. cyc-1 inside one phase.
    function automatic int tmr_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/cache_axi_master_if.sv
// cache_axi_master_if: AXI-style AR/R/AW/W/B channel bundle used by
// cache_axi_master.
// Modports:
//   master  the cache-side bus master (drives AR/AW/W, R/B ready)
//   slave   the memory side (drives arready/awready/wready, R and B)
interface cache_axi_master_if
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int ID_W   = ID_W_DEF
);
    logic [ID_W-1:0]         arid;
    logic [ADDR_W-1:0]       araddr;
    logic                    arvalid;
    logic                    arready;
    logic [ID_W-1:0]         rid;
    logic [TAG_W+DATA_W-1:0] rdata;
    logic                    rvalid;
    logic                    rready;
    logic [ID_W-1:0]         awid;
    logic [ADDR_W-1:0]       awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [ID_W-1:0]         wid;
    logic [DATA_W-1:0]       wdata;
    logic                    wvalid;
    logic                    wready;
    logic [ID_W-1:0]         bid;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output arid, araddr, arvalid, rready,
        output awid, awaddr, awvalid, wid, wdata, wvalid, bready,
        input  arready, rid, rdata, rvalid,
        input  awready, wready, bid, bvalid
    );

    modport slave (
        input  arid, araddr, arvalid, rready,
        input  awid, awaddr, awvalid, wid, wdata, wvalid, bready,
        output arready, rid, rdata, rvalid,
        output awready, wready, bid, bvalid
    );
endinterface

// File: rtl/cache_axi_master.sv
// cache_axi_master: turns single cache-line read/write requests into one AXI
// transaction at a time and returns a response to the client.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/ready/write/addr/wdata   client request channel
//   resp_valid/ready/write/rdata/err   client response channel
//   axi (cache_axi_master_if.master)   AR/R/AW/W/B bus
// Optional feature: define RESP_TIMEOUT_EN to bound every AXI phase to
// TIMEOUT_CYC cycles; on expiry the transaction completes with resp_err=1.
module cache_axi_master
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic [TAG_W+DATA_W-1:0] resp_rdata,
    output logic                    resp_err,
    cache_axi_master_if.master      axi
);

    state_t state_reg, state_next;

    logic req_ready_reg, arvalid_reg, rready_reg, awvalid_reg, wvalid_reg;
    logic bready_reg, resp_valid_reg;
    logic aw_done_reg, w_done_reg, aw_done_next, w_done_next;
    logic write_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [TAG_W+DATA_W-1:0] rdata_reg;
    logic [ID_W-1:0]         id_reg;
    logic                    timeout_hit;
    logic                    accept, resp_done;

    assign accept    = (state_reg == IDLE) && req_valid && req_ready_reg;
    assign resp_done = (state_reg == RESP) && resp_valid_reg && resp_ready;

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi.rid, axi.bid, TIMEOUT_CYC[0]};

`ifdef RESP_TIMEOUT_EN
    localparam int TMR_W = tmr_width(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] timer_reg;
    logic             waiting;
    logic             resp_err_reg;

    assign waiting     = (state_reg == AR) || (state_reg == R) ||
                         (state_reg == AW_W) || (state_reg == B);
    assign timeout_hit = waiting && (timer_reg == TMR_LAST);
    assign resp_err    = resp_err_reg;

    // Counts cycles spent in the current phase; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer_reg <= '0;
        else if (state_next != state_reg)
            timer_reg <= '0;
        else if (waiting)
            timer_reg <= timer_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resp_err_reg <= 1'b0;
        else if (timeout_hit && (state_next == RESP))
            resp_err_reg <= 1'b1;
        else if (resp_done)
            resp_err_reg <= 1'b0;
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // Next state. A handshake completing in the expiry cycle wins over timeout.
    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg | (awvalid_reg & axi.awready);
        w_done_next  = w_done_reg  | (wvalid_reg  & axi.wready);
        case (state_reg)
            IDLE: if (accept) state_next = req_write ? AW_W : AR;
            AR: begin
                if (arvalid_reg && axi.arready) state_next = R;
                else if (timeout_hit)           state_next = RESP;
            end
            R: begin
                if (rready_reg && axi.rvalid) state_next = RESP;
                else if (timeout_hit)         state_next = RESP;
            end
            AW_W: begin
                if (aw_done_next && w_done_next) state_next = B;
                else if (timeout_hit)            state_next = RESP;
            end
            B: begin
                if (bready_reg && axi.bvalid) state_next = RESP;
                else if (timeout_hit)         state_next = RESP;
            end
            RESP:    if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Per-channel acceptance flags only live while in AW_W.
        if (state_next != AW_W) begin
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Handshake outputs are registered copies of the decoded next state, so no
    // AXI input reaches an AXI output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_reg  <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            id_reg         <= '0;
        end else begin
            req_ready_reg  <= (state_next == IDLE);
            arvalid_reg    <= (state_next == AR);
            rready_reg     <= (state_next == R);
            awvalid_reg    <= (state_next == AW_W) && !aw_done_next;
            wvalid_reg     <= (state_next == AW_W) && !w_done_next;
            bready_reg     <= (state_next == B);
            resp_valid_reg <= (state_next == RESP);
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
            if (accept) begin
                write_reg <= req_write;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if ((state_reg == R) && rready_reg && axi.rvalid)
                rdata_reg <= axi.rdata;
            else if (timeout_hit)
                rdata_reg <= '0;
            if (resp_done)
                id_reg <= id_reg + 1'b1;
        end
    end

    assign req_ready   = req_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_write  = write_reg;
    assign resp_rdata  = rdata_reg;
    assign axi.arid    = id_reg;
    assign axi.araddr  = addr_reg;
    assign axi.arvalid = arvalid_reg;
    assign axi.rready  = rready_reg;
    assign axi.awid    = id_reg;
    assign axi.awaddr  = addr_reg;
    assign axi.awvalid = awvalid_reg;
    assign axi.wid     = id_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wvalid  = wvalid_reg;
    assign axi.bready  = bready_reg;

endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master: directed self-checking bench for cache_axi_master.
// A small in-bench slave answers each channel after a programmable number of
// valid cycles; latencies, IDs, handshake counts and data are compared against
// hand-computed values. Compile with RESP_TIMEOUT_EN to add the timeout case.
module tb_cache_axi_master;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [63:0]   req_addr;
    logic [511:0]  req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_write;
    logic [575:0]  resp_rdata;
    logic          resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    cache_axi_master_if #(.ADDR_W(64), .DATA_W(512), .TAG_W(64), .ID_W(16)) axi ();

    cache_axi_master #(
        .ADDR_W(64), .DATA_W(512), .TAG_W(64), .ID_W(16), .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_write (resp_write),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Issue a read; slave raises arready after ar_dly extra arvalid cycles and
    // rvalid after r_dly extra rready cycles. lat = cycles from accept edge
    // until resp_valid is seen.
    task automatic do_read(input logic [63:0] addr, input logic [575:0] line,
                           input int ar_dly, input int r_dly,
                           output int lat, output int n_ar,
                           output logic [15:0] id_seen, output logic [63:0] addr_seen);
        int n_r;
        n_ar = 0; n_r = 0; lat = 0; id_seen = '1; addr_seen = '1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; axi.rdata = line;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat = c;
            axi.arready = 1'b0;
            axi.rvalid  = 1'b0;
            if (axi.arvalid) begin
                n_ar++;
                if (n_ar == 1) begin
                    id_seen   = axi.arid;
                    addr_seen = axi.araddr;
                end
                axi.arready = (n_ar > ar_dly);
            end
            if (axi.rready) begin
                n_r++;
                axi.rvalid = (n_r > r_dly);
            end
            if (resp_valid) break;
        end
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
    endtask

    // Issue a write; each channel's ready comes after its own delay. stable
    // drops to 0 if awaddr/wdata/wid ever differ from the request.
    task automatic do_write(input logic [63:0] addr, input logic [511:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output int lat, output int n_aw, output int n_w, output int n_b,
                            output logic [15:0] id_seen, output logic stable);
        n_aw = 0; n_w = 0; n_b = 0; lat = 0; id_seen = '1; stable = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_wdata = '0;
            lat = c;
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b0;
            if (axi.awvalid) begin
                n_aw++;
                if (n_aw == 1) id_seen = axi.awid;
                if (axi.awaddr !== addr) stable = 1'b0;
                axi.awready = (n_aw > aw_dly);
            end
            if (axi.wvalid) begin
                n_w++;
                if (axi.wdata !== data || axi.wid !== id_seen) stable = 1'b0;
                axi.wready = (n_w > w_dly);
            end
            if (axi.bready) begin
                n_b++;
                axi.bvalid = (n_b > b_dly);
            end
            if (resp_valid) break;
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
    endtask

    // Hold resp_ready low for 'hold' cycles, then complete the response.
    task automatic finish_resp(input int hold, input logic [575:0] exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_resp_rdata", resp_rdata, exp_data);
            check("hold_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_cleared", resp_valid, 1'b0);
        check("back_idle_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        int lat, n_ar, n_aw, n_w, n_b, seen;
        logic [15:0]  id;
        logic [63:0]  a;
        logic         stable;
        logic [575:0] line1, line2;

        line1 = {64'h8000_0000_0000_0000, {64{8'hA5}}};
        line2 = {64'h0123_4567_89AB_CDEF, {32{16'h5A0F}}};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rvalid = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = '0; axi.bvalid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 576'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_arid", axi.arid, 16'd0);

        // Zero-wait read: resp_valid 3 cycles after accept.
        do_read(64'h0000_0000_0000_1040, line1, 0, 0, lat, n_ar, id, a);
        $display("read addr=%h lat=%0d id=%0d", a, lat, id);
        check("rd1_latency", lat, 3);
        check("rd1_arid", id, 16'd0);
        check("rd1_araddr", a, 64'h1040);
        check("rd1_ar_cycles", n_ar, 1);
        check("rd1_rdata", resp_rdata, line1);
        check("rd1_resp_write", resp_write, 1'b0);
        check("rd1_resp_err", resp_err, 1'b0);
        check("rd1_arvalid_low", axi.arvalid, 1'b0);
        finish_resp(5, line1);

        // Write, both readies 2 cycles late, B in the first bready cycle.
        do_write(64'h40, {64{8'h3C}}, 2, 2, 0, lat, n_aw, n_w, n_b, id, stable);
        $display("write addr=40 lat=%0d id=%0d aw=%0d w=%0d b=%0d", lat, id, n_aw, n_w, n_b);
        check("wr1_latency", lat, 5);
        check("wr1_id", id, 16'd1);
        check("wr1_aw_cycles", n_aw, 3);
        check("wr1_w_cycles", n_w, 3);
        check("wr1_b_cycles", n_b, 1);
        check("wr1_stable", stable, 1'b1);
        check("wr1_resp_write", resp_write, 1'b1);
        check("wr1_resp_err", resp_err, 1'b0);
        finish_resp(0, resp_rdata);

        // awready one cycle before wready: awvalid drops first.
        do_write(64'h80, {8{64'hFEDC_BA98_7654_3210}}, 1, 2, 0, lat, n_aw, n_w, n_b, id, stable);
        $display("write addr=80 lat=%0d id=%0d aw=%0d w=%0d b=%0d", lat, id, n_aw, n_w, n_b);
        check("wr2_latency", lat, 5);
        check("wr2_id", id, 16'd2);
        check("wr2_aw_cycles", n_aw, 2);
        check("wr2_w_cycles", n_w, 3);
        check("wr2_b_cycles", n_b, 1);
        check("wr2_stable", stable, 1'b1);
        finish_resp(0, resp_rdata);

        // W accepted first, AW late, B delayed two cycles.
        do_write(64'hC0, {16{32'h1234_5678}}, 3, 0, 2, lat, n_aw, n_w, n_b, id, stable);
        $display("write addr=c0 lat=%0d id=%0d aw=%0d w=%0d b=%0d", lat, id, n_aw, n_w, n_b);
        check("wr3_latency", lat, 8);
        check("wr3_id", id, 16'd3);
        check("wr3_aw_cycles", n_aw, 4);
        check("wr3_w_cycles", n_w, 1);
        check("wr3_b_cycles", n_b, 3);
        check("wr3_stable", stable, 1'b1);
        finish_resp(0, resp_rdata);

        // Read with wait states on both AR and R.
        do_read(64'hDEAD_BEEF_0000_0FC0, line2, 2, 1, lat, n_ar, id, a);
        $display("read addr=%h lat=%0d id=%0d", a, lat, id);
        check("rd2_latency", lat, 6);
        check("rd2_arid", id, 16'd4);
        check("rd2_araddr", a, 64'hDEAD_BEEF_0000_0FC0);
        check("rd2_ar_cycles", n_ar, 3);
        check("rd2_rdata", resp_rdata, line2);
        check("rd2_resp_write", resp_write, 1'b0);
        finish_resp(0, line2);

        // Reset while waiting in R: outputs clear at once, no late response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_arid", axi.arid, 16'd5);
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        check("rst_mid_in_r", axi.rready, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rready", axi.rready, 1'b0);
        check("rst_mid_arvalid", axi.arvalid, 1'b0);
        check("rst_mid_resp_valid", resp_valid, 1'b0);
        check("rst_mid_arid_clr", axi.arid, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        axi.rvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid || axi.rready || axi.arvalid) seen++;
        end
        axi.rvalid = 1'b0;
        $display("reset mid-read: spurious activity cycles=%0d", seen);
        check("rst_mid_no_resp", seen, 0);

        // First transaction after reset starts again from ID 0.
        do_read(64'h2000, line2, 0, 0, lat, n_ar, id, a);
        $display("read addr=%h lat=%0d id=%0d", a, lat, id);
        check("rd3_arid", id, 16'd0);
        check("rd3_latency", lat, 3);
        check("rd3_rdata", resp_rdata, line2);
        finish_resp(0, line2);

`ifdef RESP_TIMEOUT_EN
        // arready never comes: 8 cycles in AR, then an error response.
        do_read(64'h3000, line1, 100, 0, lat, n_ar, id, a);
        $display("timeout read addr=%h lat=%0d ar_cycles=%0d err=%0d", a, lat, n_ar, resp_err);
        check("to_ar_cycles", n_ar, 8);
        check("to_latency", lat, 9);
        check("to_arvalid_low", axi.arvalid, 1'b0);
        check("to_resp_err", resp_err, 1'b1);
        check("to_resp_rdata", resp_rdata, 576'd0);
        finish_resp(0, 576'd0);
        check("to_err_cleared", resp_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_axi_master.md
CACHE_AXI_MASTER -- requirements
Module: cache_axi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning AXI address width.
REQ-002 SHALL have parameter DATA_W, default 512, meaning line data width.
REQ-003 SHALL have parameter TAG_W, default 64, meaning tag word width carried on R ahead of data.
REQ-004 SHALL have parameter ID_W, default 16, meaning AXI ID width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255, meaning max wait cycles per AXI phase.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have client ports: req_valid in 1; req_ready out 1; req_write in 1 (1=write, 0=read); req_addr in ADDR_W; req_wdata in DATA_W.
REQ-008 SHALL have client ports: resp_valid out 1; resp_ready in 1; resp_write out 1; resp_rdata out TAG_W+DATA_W (tag in MSBs); resp_err out 1.
REQ-009 SHALL have AR/R ports: arid out ID_W; araddr out ADDR_W; arvalid out 1; arready in 1; rid in ID_W; rdata in TAG_W+DATA_W; rvalid in 1; rready out 1.
REQ-010 SHALL have AW/W/B ports: awid out ID_W; awaddr out ADDR_W; awvalid out 1; awready in 1; wid out ID_W; wdata out DATA_W; wvalid out 1; wready in 1; bid in ID_W; bvalid in 1; bready out 1.

Function
REQ-011 SHALL use states IDLE, AR, R, AW_W, B, RESP; one transaction in flight.
REQ-012 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid&&req_ready, latching addr, wdata, write flag.
REQ-013 SHALL go IDLE->AR (read) or IDLE->AW_W (write) on accept; arvalid or awvalid/wvalid high the next cycle.
REQ-014 SHALL hold arvalid and araddr stable in AR until arready sampled high, then go to R.
REQ-015 SHALL drive rready=1 in R; on rvalid capture rdata into resp_rdata and go to RESP.
REQ-016 SHALL in AW_W assert awvalid and wvalid together, dropping each independently after its own ready; go to B when both accepted (same cycle or any order).
REQ-017 SHALL drive bready=1 in B; on bvalid go to RESP.
REQ-018 SHALL assert resp_valid in RESP, holding resp_* stable until resp_ready, then return to IDLE; resp_write echoes latched request type.
REQ-019 SHALL drive arid/awid/wid from an ID_W-bit counter incremented once per completed transaction, wrapping from all-ones to 0; rid/bid are ignored.
REQ-020 SHALL drive all AXI valid/ready outputs from registers (no combinational path from AXI inputs).
REQ-021 SHALL give read latency, accept to resp_valid, of 3 cycles with zero-wait slave (arready and rvalid first cycle offered).

Reset
REQ-022 SHALL on rst_n low, asynchronously: state IDLE, all valid/ready outputs 0, resp_err 0, ID counter 0, resp_rdata 0.
REQ-023 SHALL on reset mid-transaction abandon it silently; no response issued after reset release.

Configuration
REQ-024 SHALL, with RESP_TIMEOUT_EN defined, count cycles in AR, R, AW_W, B; on reaching TIMEOUT_CYC drop all AXI valids/readies, go to RESP with resp_err=1, resp_rdata=0.
REQ-025 SHALL, without RESP_TIMEOUT_EN, omit the counter, wait indefinitely, tie resp_err to 0.
REQ-026 SHALL reset the timeout counter on each state change.

Structure
REQ-027 SHALL place width defaults and the state enum in package cache_axi_pkg.
REQ-028 SHALL be single module; no sub-module.

Verification
REQ-029 Read 0x0000_0000_0000_1040 with zero-wait slave returning tag 0x8000_0000_0000_0000, data all 0xA5 -> resp_valid at +3 cycles, resp_rdata matches, resp_write=0, arid=0.
REQ-030 Write 0x40, wdata all 0x3C, slave raising awready/wready 2 cycles after valid, bvalid 1 cycle later -> wdata held stable, single bready cycle, resp_write=1, next ID=1.
REQ-031 Write with awready 1 cycle before wready -> awvalid drops first, wvalid held until wready, one B wait.
REQ-032 resp_ready low 5 cycles -> resp_valid and data held, req_ready stays 0.
REQ-033 rst_n pulsed low while in R -> arvalid/rready 0 immediately, no resp_valid after release, ID=0.
REQ-034 RESP_TIMEOUT_EN, TIMEOUT_CYC=8, slave never raises arready -> arvalid drops, resp_valid with resp_err=1 after 8 cycles in AR.
